// File: rtl/audio_codec_i2c_config.sv
// audio_codec_i2c_config
//  Power-up / on-demand configurator for a WM8731 codec. Walks a fixed
//  11-word register table over a write-only, single-master I2C bus and
//  leaves the codec in master mode, left-justified, 24-bit, ADC/DAC active.
//  Downstream audio logic gates on done.
//
//  Optional feature macro: AUDIO_CFG_RETRY_EN
//    defined   : a NACKed word is retransmitted up to MAX_RETRY times.
//    undefined : the first NACK aborts the sequence with error=1.
//
// Ports
//  clk        in     system clock
//  reset_n    in     synchronous active-low reset
//  start      in     1-cycle pulse, run the table from index 0 (ignored while busy)
//  busy       out    sequence in progress
//  done       out    all words ACKed; held until next start/reset
//  error      out    sequence aborted on NACK; held until next start/reset
//  cfg_index  out    table index of the current or last word
//  I2C_SCLK   out    SCL, push-pull
//  I2C_SDAT   inout  SDA, open-drain (drives 0 or Z)
module audio_codec_i2c_config #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned I2C_FREQ_HZ = 100_000,
   parameter logic [7:0]  DEV_ADDR    = 8'h34,
   parameter bit          AUTO_START  = 1'b1,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] cfg_index,
   output logic       I2C_SCLK,
   inout  wire        I2C_SDAT
);

   localparam int unsigned QDIV     = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
   localparam int unsigned QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [3:0]  LAST_IDX = 4'd10;

   // Reject parameter sets the quarter-bit timer or retry counter cannot represent.
   if (QDIV < 2 || MAX_RETRY > 15) begin : g_param_chk
      $error("audio_codec_i2c_config: unsupported CLK/I2C ratio or MAX_RETRY");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SEND, S_ACK, S_STOP, S_GAP, S_FIN, S_ERR
   } state_t;

   state_t          r_state, w_state_n;
   logic [QW-1:0]   r_qcnt,  w_qcnt_n;
   logic [1:0]      r_q,     w_q_n;
   logic [2:0]      r_bit,   w_bit_n;
   logic [1:0]      r_byte,  w_byte_n;
   logic [3:0]      r_idx,   w_idx_n;
   logic            r_nack,  w_nack_n;
   logic            r_last,  w_last_n;
   logic            r_auto,  w_auto_n;
   logic            r_busy,  w_busy_n;
   logic            r_done,  w_done_n;
   logic            r_error, w_error_n;
   logic            r_scl,   w_scl_c;
   logic            r_sda_lo, w_sda_lo_c;
`ifdef AUDIO_CFG_RETRY_EN
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]   r_retry, w_retry_n;
`endif

   logic            w_tick, w_bit_end, w_timed, w_sda_in, w_bit_val;
   logic [15:0]     w_word;
   logic [7:0]      w_byte_val;

   // Register table: {reg[6:0], data[8:0]}
   function automatic logic [15:0] f_word(input logic [3:0] idx);
      case (idx)
         4'd0:    f_word = {7'd15, 9'h000};
         4'd1:    f_word = {7'd0,  9'h017};
         4'd2:    f_word = {7'd1,  9'h017};
         4'd3:    f_word = {7'd2,  9'h079};
         4'd4:    f_word = {7'd3,  9'h079};
         4'd5:    f_word = {7'd4,  9'h012};
         4'd6:    f_word = {7'd5,  9'h000};
         4'd7:    f_word = {7'd6,  9'h000};
         4'd8:    f_word = {7'd7,  9'h049};
         4'd9:    f_word = {7'd8,  9'h000};
         default: f_word = {7'd9,  9'h001};
      endcase
   endfunction

   assign w_sda_in   = I2C_SDAT;
   assign w_word     = f_word(r_idx);
   assign w_byte_val = (r_byte == 2'd0) ? DEV_ADDR :
                       (r_byte == 2'd1) ? w_word[15:8] : w_word[7:0];
   assign w_bit_val  = w_byte_val[r_bit];
   assign w_tick     = (r_qcnt == QW'(QDIV - 1));
   assign w_bit_end  = w_tick && (r_q == 2'd3);
   assign w_timed    = (r_state == S_START) || (r_state == S_SEND) || (r_state == S_ACK) ||
                       (r_state == S_STOP)  || (r_state == S_GAP);

   // State register; bus pins are registered from the decode of the current quarter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_qcnt   <= '0;
         r_q      <= '0;
         r_bit    <= 3'd7;
         r_byte   <= '0;
         r_idx    <= '0;
         r_nack   <= 1'b0;
         r_last   <= 1'b0;
         r_auto   <= AUTO_START;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_scl    <= 1'b1;
         r_sda_lo <= 1'b0;
`ifdef AUDIO_CFG_RETRY_EN
         r_retry  <= '0;
`endif
      end else begin
         r_state  <= w_state_n;
         r_qcnt   <= w_qcnt_n;
         r_q      <= w_q_n;
         r_bit    <= w_bit_n;
         r_byte   <= w_byte_n;
         r_idx    <= w_idx_n;
         r_nack   <= w_nack_n;
         r_last   <= w_last_n;
         r_auto   <= w_auto_n;
         r_busy   <= w_busy_n;
         r_done   <= w_done_n;
         r_error  <= w_error_n;
         r_scl    <= w_scl_c;
         r_sda_lo <= w_sda_lo_c;
`ifdef AUDIO_CFG_RETRY_EN
         r_retry  <= w_retry_n;
`endif
      end
   end

   // Next-state, quarter timer and bus-level decode.
   always_comb begin
      w_state_n  = r_state;
      w_qcnt_n   = r_qcnt;
      w_q_n      = r_q;
      w_bit_n    = r_bit;
      w_byte_n   = r_byte;
      w_idx_n    = r_idx;
      w_nack_n   = r_nack;
      w_last_n   = r_last;
      w_auto_n   = 1'b0;
      w_busy_n   = r_busy;
      w_done_n   = r_done;
      w_error_n  = r_error;
      w_scl_c    = 1'b1;
      w_sda_lo_c = 1'b0;
`ifdef AUDIO_CFG_RETRY_EN
      w_retry_n  = r_retry;
`endif

      // Every bus state lasts exactly four quarters; q wraps to 0 at bit end.
      if (w_timed) begin
         w_qcnt_n = w_tick ? '0 : r_qcnt + QW'(1);
         if (w_tick) begin
            w_q_n = r_q + 2'd1;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (start || r_auto) begin
               w_state_n = S_START;
               w_qcnt_n  = '0;
               w_q_n     = '0;
               w_bit_n   = 3'd7;
               w_byte_n  = '0;
               w_idx_n   = '0;
               w_nack_n  = 1'b0;
               w_last_n  = 1'b0;
               w_busy_n  = 1'b1;
               w_done_n  = 1'b0;
               w_error_n = 1'b0;
`ifdef AUDIO_CFG_RETRY_EN
               w_retry_n = '0;
`endif
            end
         end
         S_START: begin
            // q0 idle, q1 SDA falls under high SCL, q2/q3 SCL low
            w_scl_c    = (r_q == 2'd0) || (r_q == 2'd1);
            w_sda_lo_c = (r_q != 2'd0);
            if (w_bit_end) begin
               w_state_n = S_SEND;
               w_bit_n   = 3'd7;
               w_byte_n  = '0;
            end
         end
         S_SEND: begin
            w_scl_c    = (r_q == 2'd1) || (r_q == 2'd2);
            w_sda_lo_c = !w_bit_val;
            if (w_bit_end) begin
               if (r_bit == 3'd0) begin
                  w_state_n = S_ACK;
               end else begin
                  w_bit_n = r_bit - 3'd1;
               end
            end
         end
         S_ACK: begin
            w_scl_c = (r_q == 2'd1) || (r_q == 2'd2);
            if (w_tick && (r_q == 2'd2)) begin
               w_nack_n = w_sda_in;
            end
            if (w_bit_end) begin
               if (r_nack || (r_byte == 2'd2)) begin
                  w_state_n = S_STOP;
               end else begin
                  w_state_n = S_SEND;
                  w_byte_n  = r_byte + 2'd1;
                  w_bit_n   = 3'd7;
               end
            end
         end
         S_STOP: begin
            // q0 SCL low/SDA low, q1 SCL rises, q2 SDA rises under high SCL
            w_scl_c    = (r_q != 2'd0);
            w_sda_lo_c = (r_q == 2'd0) || (r_q == 2'd1);
            if (w_bit_end) begin
               if (!r_nack) begin
                  w_state_n = S_GAP;
`ifdef AUDIO_CFG_RETRY_EN
                  w_retry_n = '0;
`endif
                  if (r_idx == LAST_IDX) begin
                     w_last_n = 1'b1;
                  end else begin
                     w_idx_n = r_idx + 4'd1;
                  end
               end else begin
`ifdef AUDIO_CFG_RETRY_EN
                  if (r_retry < RW'(MAX_RETRY)) begin
                     w_retry_n = r_retry + RW'(1);
                     w_state_n = S_GAP;
                  end else begin
                     w_state_n = S_ERR;
                     w_error_n = 1'b1;
                     w_busy_n  = 1'b0;
                  end
`else
                  w_state_n = S_ERR;
                  w_error_n = 1'b1;
                  w_busy_n  = 1'b0;
`endif
               end
            end
         end
         S_GAP: begin
            // Bus free; a pending NACK here means the same word is resent.
            if (w_bit_end) begin
               if (r_last) begin
                  w_state_n = S_FIN;
                  w_done_n  = 1'b1;
                  w_busy_n  = 1'b0;
               end else begin
                  w_state_n = S_START;
                  w_bit_n   = 3'd7;
                  w_byte_n  = '0;
                  w_nack_n  = 1'b0;
               end
            end
         end
         S_FIN:   w_state_n = S_IDLE;
         S_ERR:   w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;
   assign cfg_index = r_idx;
   assign I2C_SCLK  = r_scl;
   assign I2C_SDAT  = r_sda_lo ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_audio_codec_i2c_config.sv
// tb_audio_codec_i2c_config
//  Directed bench: I2C slave/bus monitor decodes transactions, optionally
//  NACKs a chosen byte of a chosen word, and checks table contents, bus
//  timing, NACK handling, start filtering and mid-transfer reset.
module tb_audio_codec_i2c_config;

   localparam int QDIV     = 4;
   localparam int PER      = 4 * QDIV;
   localparam int WAIT_LIM = 12000;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       busy, done, error;
   logic [3:0] cfg_index;
   logic       scl;
   wire        sda_bus;
   logic       slave_low;

   pullup (sda_bus);
   assign sda_bus = slave_low ? 1'b0 : 1'bz;

   audio_codec_i2c_config #(
      .CLK_FREQ_HZ(16_000_000),
      .I2C_FREQ_HZ(1_000_000),
      .DEV_ADDR   (8'h34),
      .AUTO_START (1'b1),
      .MAX_RETRY  (3)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .cfg_index(cfg_index),
      .I2C_SCLK (scl),
      .I2C_SDAT (sda_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks, n_err;
   logic [15:0] exp_w [0:10];

   // monitor state
   logic        clr_req;
   int          nack_word, nack_byte, nack_limit;
   int          n_start, n_stop, n_tr, words_ok, attempts, nacks_done, n_bad;
   int          min_per, max_per, min_gap, t, last_rise, last_stop_t, bitcnt, nbytes;
   logic [23:0] tr_data [0:63];
   int          tr_n [0:63];
   logic [7:0]  cur_b;
   logic [23:0] cur;
   logic        all_ack, in_xfer, p_scl, p_sda;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor and slave responder, sampled on the falling clock edge.
   initial begin
      slave_low = 1'b0;
      forever begin
         logic sv;
         @(negedge clk);
         sv = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
         if (!reset_n || clr_req) begin
            n_start = 0; n_stop = 0; n_tr = 0; words_ok = 0; attempts = 0;
            nacks_done = 0; n_bad = 0; min_per = 1 << 30; max_per = 0;
            min_gap = 1 << 30; t = 0; last_rise = -1; last_stop_t = -1;
            bitcnt = 0; nbytes = 0; cur_b = '0; cur = '0; all_ack = 1'b1;
            in_xfer = 1'b0; p_scl = 1'b1; p_sda = 1'b1; slave_low = 1'b0;
         end else begin
            if (scl && p_scl && p_sda && !sv) begin
               if (in_xfer) n_bad++;
               in_xfer = 1'b1; bitcnt = 0; nbytes = 0; cur = '0; all_ack = 1'b1;
               n_start++;
               if (words_ok == nack_word) attempts++;
               if (last_stop_t >= 0 && (t - last_stop_t) < min_gap) min_gap = t - last_stop_t;
               last_rise = -1;
            end else if (scl && p_scl && !p_sda && sv) begin
               // STOP follows its own SCL rise, which the rising branch counted as a bit
               if (!in_xfer || bitcnt > 1) n_bad++;
               if (in_xfer) begin
                  if (n_tr < 64) begin
                     tr_data[n_tr] = cur;
                     tr_n[n_tr]    = nbytes;
                  end
                  n_tr++;
                  n_stop++;
                  if (nbytes == 3 && all_ack) words_ok++;
               end
               in_xfer = 1'b0;
               last_stop_t = t;
            end else if (scl && !p_scl) begin
               if (in_xfer) begin
                  if (last_rise >= 0) begin
                     if ((t - last_rise) < min_per) min_per = t - last_rise;
                     if ((t - last_rise) > max_per) max_per = t - last_rise;
                  end
                  last_rise = t;
                  if (bitcnt < 8) begin
                     cur_b = {cur_b[6:0], sv};
                     bitcnt++;
                  end else begin
                     cur = {cur[15:0], cur_b};
                     nbytes++;
                     bitcnt = 0;
                     if (sv) all_ack = 1'b0;
                  end
               end
            end else if (!scl && p_scl) begin
               if (in_xfer && bitcnt == 8) begin
                  if (words_ok == nack_word && nbytes == nack_byte && nacks_done < nack_limit) begin
                     slave_low = 1'b0;
                     nacks_done++;
                  end else begin
                     slave_low = 1'b1;
                  end
               end else begin
                  slave_low = 1'b0;
               end
            end
            p_scl = scl;
            p_sda = sv;
            t++;
         end
      end
   end

   task automatic tick_n();
      @(negedge clk);
      #1;
   endtask

   task automatic do_clear();
      clr_req = 1'b1;
      @(negedge clk);
      #1;
      clr_req = 1'b0;
   endtask

   task automatic pulse_start();
      tick_n();
      start = 1'b1;
      tick_n();
      start = 1'b0;
   endtask

   task automatic wait_end();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         tick_n();
         if (done || error) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_end", ok, 1'b1);
   endtask

   task automatic wait_words(input int n);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         tick_n();
         if (words_ok >= n) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_words", ok, 1'b1);
   endtask

   task automatic check_table();
      check("n_tr", n_tr, 11);
      for (int i = 0; i < 11; i++) begin
         check("tr_bytes", tr_n[i], 3);
         check("tr_word", tr_data[i], {8'h34, exp_w[i]});
      end
   endtask

   initial begin
      logic ok;
      exp_w[0] = 16'h1E00; exp_w[1] = 16'h0017; exp_w[2]  = 16'h0217;
      exp_w[3] = 16'h0479; exp_w[4] = 16'h0679; exp_w[5]  = 16'h0812;
      exp_w[6] = 16'h0A00; exp_w[7] = 16'h0C00; exp_w[8]  = 16'h0E49;
      exp_w[9] = 16'h1000; exp_w[10] = 16'h1201;
      n_checks = 0; n_err = 0;
      reset_n = 1'b0; start = 1'b0; clr_req = 1'b0;
      nack_word = 15; nack_byte = 0; nack_limit = 0;

      // reset values and auto start
      tick_n(); tick_n();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_index", cfg_index, 4'd0);
      check("rst_scl", scl, 1'b1);
      check("rst_sda", (sda_bus === 1'b0) ? 1'b0 : 1'b1, 1'b1);
      reset_n = 1'b1;
      tick_n();
      check("auto_busy", busy, 1'b1);

      // full table with an always-ACK slave, plus bus timing
      wait_end();
      check("t1_done", done, 1'b1);
      check("t1_busy", busy, 1'b0);
      check("t1_error", error, 1'b0);
      check("t1_index", cfg_index, 4'd10);
      check_table();
      check("scl_per_min", min_per, PER);
      check("scl_per_max", max_per, PER);
      check("bus_gap", (min_gap >= PER) ? 1 : 0, 1);
      check("bad_edges", n_bad, 0);

      // start after done replays; start while busy is dropped
      do_clear();
      pulse_start();
      check("t5_done_drop", done, 1'b0);
      check("t5_busy", busy, 1'b1);
      wait_words(3);
      pulse_start();
      wait_end();
      check("t5_done", done, 1'b1);
      check("t5_starts", n_start, 11);
      check_table();

`ifndef AUDIO_CFG_RETRY_EN
      // NACK on data byte of index 4 aborts
      do_clear();
      nack_word = 4; nack_byte = 2; nack_limit = 1;
      pulse_start();
      wait_end();
      check("t3_error", error, 1'b1);
      check("t3_done", done, 1'b0);
      check("t3_busy", busy, 1'b0);
      check("t3_index", cfg_index, 4'd4);
      repeat (20 * PER) tick_n();
      check("t3_starts", n_start, 5);
      check("t3_stops", n_stop, 5);
      check("t3_last_bytes", tr_n[4], 3);
      check("t3_last_word", tr_data[4], 24'h340679);
`else
      // two NACKs on index 2 are recovered by retries
      do_clear();
      nack_word = 2; nack_byte = 0; nack_limit = 2;
      pulse_start();
      wait_end();
      check("t4a_done", done, 1'b1);
      check("t4a_error", error, 1'b0);
      check("t4a_attempts", attempts, 3);
      check("t4a_starts", n_start, 13);
      check("t4a_index", cfg_index, 4'd10);
      // four NACKs exhaust the retries
      do_clear();
      nack_limit = 4;
      pulse_start();
      wait_end();
      check("t4b_error", error, 1'b1);
      check("t4b_done", done, 1'b0);
      check("t4b_attempts", attempts, 4);
      check("t4b_index", cfg_index, 4'd2);
      repeat (20 * PER) tick_n();
      check("t4b_starts", n_start, 6);
`endif

      // reset in the middle of a bit of index 6, then automatic restart
      do_clear();
      nack_word = 15; nack_limit = 0;
      pulse_start();
      check("t6_err_clear", error, 1'b0);
      check("t6_busy", busy, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < WAIT_LIM; i++) begin
         tick_n();
         if (words_ok == 6 && in_xfer && nbytes == 1 && bitcnt == 3) begin
            ok = 1'b1;
            break;
         end
      end
      check("t6_reach", ok, 1'b1);
      reset_n = 1'b0;
      tick_n();
      check("t6_scl", scl, 1'b1);
      check("t6_sda", (sda_bus === 1'b0) ? 1'b0 : 1'b1, 1'b1);
      check("t6_busy_rst", busy, 1'b0);
      tick_n();
      reset_n = 1'b1;
      wait_end();
      check("t6_done", done, 1'b1);
      check("t6_index", cfg_index, 4'd10);
      check_table();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
